// File: rtl/polar_pkg.sv
// Shared types, defaults and configuration checks for the polar frame loader.
package polar_pkg;

  typedef enum logic [2:0] {
    FETCH_RD,
    FETCH_CAP,
    FETCH_GAP,
    MAP,
    OUT
  } loaderState_e;

  localparam int              DEFAULT_WIDTH     = 8;
  localparam int              DEFAULT_N         = 16;
  localparam int              DEFAULT_K         = 8;
  localparam logic [15:0]     DEFAULT_INFO_MASK = 16'hFE80;
  localparam int              MAX_MASK_BITS     = 1024;

  function automatic int popcount(input logic [MAX_MASK_BITS-1:0] mask);
    int count;
    count = 0;
    for (int b = 0; b < MAX_MASK_BITS; b++) begin
      if (mask[b]) count++;
    end
    return count;
  endfunction

  // A configuration is usable only if the mask selects exactly K positions
  // and the info block splits into whole FIFO words.
  function automatic bit maskValid(input logic [MAX_MASK_BITS-1:0] mask,
                                   input int k, input int width);
    return (width > 0) && (k > 0) && (popcount(mask) == k) && ((k % width) == 0);
  endfunction

  localparam bit DEFAULT_CFG_OK = maskValid(MAX_MASK_BITS'(DEFAULT_INFO_MASK),
                                            DEFAULT_K, DEFAULT_WIDTH);

endpackage

// File: rtl/polar_info_mapper.sv
// Scatters K info bits into the N-bit u vector, one position per cycle,
// placing info bits at set mask positions and zeros elsewhere.
module polar_info_mapper
  import polar_pkg::*;
#(
  parameter int           N         = DEFAULT_N,
  parameter int           K         = DEFAULT_K,
  parameter logic [N-1:0] INFO_MASK = N'(DEFAULT_INFO_MASK)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [K-1:0] info_i,
  output logic         done_o,
  output logic [N-1:0] u_o
);

  localparam int IW = $clog2(N);
  localparam int JW = $clog2(K + 1);

  logic          active_q, active_d;
  logic [IW-1:0] pos_q, pos_d;
  logic [JW-1:0] infoIdx_q, infoIdx_d;
  logic [N-1:0]  u_q, u_d;
  logic          infoBit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q  <= 1'b0;
      pos_q     <= '0;
      infoIdx_q <= '0;
      u_q       <= '0;
    end else begin
      active_q  <= active_d;
      pos_q     <= pos_d;
      infoIdx_q <= infoIdx_d;
      u_q       <= u_d;
    end
  end

  always_comb begin
    infoBit = 1'b0;
    for (int b = 0; b < K; b++) begin
      if (infoIdx_q == JW'(b)) infoBit = info_i[b];
    end
  end

  // Position i is written in the cycle it is visited; j advances only on info positions.
  always_comb begin
    active_d  = active_q;
    pos_d     = pos_q;
    infoIdx_d = infoIdx_q;
    u_d       = u_q;
    if (start_i) begin
      active_d  = 1'b1;
      pos_d     = '0;
      infoIdx_d = '0;
    end else if (active_q) begin
      if (INFO_MASK[pos_q]) begin
        u_d[pos_q] = infoBit;
        infoIdx_d  = infoIdx_q + JW'(1);
      end else begin
        u_d[pos_q] = 1'b0;
      end
      pos_d = pos_q + IW'(1);
      if (pos_q == IW'(N - 1)) active_d = 1'b0;
    end
  end

  assign done_o = active_q && (pos_q == IW'(N - 1));
  assign u_o    = u_q;

endmodule

// File: rtl/polar_frame_loader.sv
// Pulls info words from the async FIFO read port, maps them into a polar u
// vector and offers it to the butterfly encoder over valid/ready.
module polar_frame_loader
  import polar_pkg::*;
#(
  parameter int           WIDTH     = DEFAULT_WIDTH,
  parameter int           N         = DEFAULT_N,
  parameter int           K         = DEFAULT_K,
  parameter logic [N-1:0] INFO_MASK = N'(DEFAULT_INFO_MASK)
) (
  input  logic             rclk,
  input  logic             rst,
  output logic             rinc,
  input  logic [WIDTH-1:0] rdata,
  input  logic             rempty,
  output logic [N-1:0]     u_vec,
  output logic             u_valid,
  input  logic             u_ready,
  output logic             busy
);

  localparam int W  = K / WIDTH;
  localparam int CW = $clog2(W) + 1;

  if (!maskValid(MAX_MASK_BITS'(INFO_MASK), K, WIDTH)) begin : gBadConfig
    $error("polar_frame_loader: popcount(INFO_MASK) must equal K and K must be a multiple of WIDTH");
  end

  loaderState_e  state_q, state_d;
  logic [CW-1:0] wordCnt_q, wordCnt_d;
  logic [K-1:0]  info_q, info_d;
  logic          rincRaw;
  logic          mapStart;
  logic          mapDone;

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH_RD;
      wordCnt_q <= '0;
      info_q    <= '0;
    end else begin
      state_q   <= state_d;
      wordCnt_q <= wordCnt_d;
      info_q    <= info_d;
    end
  end

  // The GAP cycle gives the FIFO's registered empty flag time to reflect the
  // read just taken, so rempty is only ever trusted in FETCH_RD.
  always_comb begin
    state_d   = state_q;
    wordCnt_d = wordCnt_q;
    info_d    = info_q;
    rincRaw   = 1'b0;
    mapStart  = 1'b0;
    case (state_q)
      FETCH_RD: begin
        if (!rempty) begin
          rincRaw = 1'b1;
          state_d = FETCH_CAP;
        end
      end
      FETCH_CAP: begin
        for (int w = 0; w < W; w++) begin
          if (wordCnt_q == CW'(w)) info_d[w*WIDTH +: WIDTH] = rdata;
        end
        wordCnt_d = wordCnt_q + CW'(1);
        state_d   = FETCH_GAP;
      end
      FETCH_GAP: begin
        if (wordCnt_q == CW'(W)) begin
          wordCnt_d = '0;
          mapStart  = 1'b1;
          state_d   = MAP;
        end else begin
          state_d = FETCH_RD;
        end
      end
      MAP: begin
        if (mapDone) state_d = OUT;
      end
      OUT: begin
        if (u_ready) begin
          info_d  = '0;
          state_d = FETCH_RD;
        end
      end
      default: state_d = FETCH_RD;
    endcase
  end

  polar_info_mapper #(
    .N        (N),
    .K        (K),
    .INFO_MASK(INFO_MASK)
  ) uMapper (
    .clk_i  (rclk),
    .rst_i  (rst),
    .start_i(mapStart),
    .info_i (info_q),
    .done_o (mapDone),
    .u_o    (u_vec)
  );

  // Reset forces FETCH_RD, so the read request is masked to keep it low while reset is held.
  assign rinc    = rincRaw & ~rst;
  assign u_valid = (state_q == OUT);
  assign busy    = !((state_q == FETCH_RD) && (wordCnt_q == '0));

endmodule
